// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   UART receive controller. Synchronizes the raw rx pin through two flops,
//   detects the start bit, and samples each bit at its middle using an
//   oversampling tick. Data bits arrive LSB first. The stop bit is checked,
//   and each good byte is handed to the consumer over a valid/ready handshake.
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   rx           raw asynchronous UART line, idle high
//   rx_data      received byte; stable while rx_valid is high
//   rx_valid     byte available; held until accepted
//   rx_ready     consumer accepts on a clock edge where rx_valid & rx_ready
//   framing_err  1-cycle pulse: stop bit sampled low
//   overrun      1-cycle pulse: byte completed while the previous byte was still held
//   busy         high whenever the receiver is not idle
module uart_rx_sampler #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TICK_RAW = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
  localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OS_W     = $clog2(OVERSAMPLE);
  localparam int BIT_W    = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
  localparam logic [OS_W-1:0]  OS_MAX  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BRK
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 framing_err_q, framing_err_d;
  logic                 overrun_q, overrun_d;
  logic                 tick;
  logic                 deliver;

  assign tick = (div_cnt_q == DIV_MAX);

  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    os_cnt_d      = os_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    deliver       = 1'b0;
    framing_err_d = 1'b0;

    if (state_q != ST_IDLE) begin
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        // Divider parked at 0 so the first tick lands TICK_DIV clocks after the edge.
        div_cnt_d = '0;
        if (!rx_s_q) begin
          state_d  = ST_START;
          os_cnt_d = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (os_cnt_q == OS_HALF) begin
            os_cnt_d = '0;
            if (!rx_s_q) begin
              state_d   = ST_DATA;
              bit_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (os_cnt_q == OS_MAX) begin
            os_cnt_d = '0;
            shift_d  = {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BIT_MAX) begin
              state_d = ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (os_cnt_q == OS_MAX) begin
            os_cnt_d = '0;
            if (rx_s_q) begin
              deliver = 1'b1;
              state_d = ST_IDLE;
            end else begin
              framing_err_d = 1'b1;
              state_d       = ST_BRK;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
      end
      ST_BRK: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output handshake: an accept in the same cycle as a delivery frees the
  // slot, so the new byte replaces the old one without an overrun.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      div_cnt_q     <= '0;
      os_cnt_q      <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_meta_q     <= rx;
      rx_s_q        <= rx_meta_q;
      div_cnt_q     <= div_cnt_d;
      os_cnt_q      <= os_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
